iobus_vram_bridge: RTL and testbench
====================================

Name: iobus_vram_bridge

Overview:
- Parametrised memory-mapped bridge between the OTTER IOBUS and the GPU VRAM port. It replaces the single-cycle direct VRAM write registers.
- CPU VRAM writes are posted into a write FIFO and drained to the GPU with a valid/ready handshake.
- A hardware fill engine writes a run of pixels with one colour.
- Status is readable over IOBUS, and the block raises an interrupt when a fill completes.

Parameters:
- BASE_ADDR, 32'h1100C00C, IOBUS base address of the register window; must be word aligned.
- ADDR_W, 16, VRAM address width.
- DATA_W, 12, pixel width; legal range 1..16.
- FIFO_DEPTH, 8, write FIFO entries; power of two, 2..128.

Ports:
- clk  in  1  system clock (s_clk domain)
- RST  in  1  asynchronous active-high reset
- iobus_addr_i  in  32  IOBUS address
- iobus_wr_i  in  1  IOBUS write strobe
- iobus_out_i  in  32  CPU write data
- iobus_in_o  out  32  read data; 0 when the address is outside the window, so it can be OR'd into the wrapper mux
- vram_we_o  out  1  write valid to GPU
- vram_waddr_o  out  ADDR_W  write address
- vram_wdata_o  out  DATA_W  write pixel
- vram_rdy_i  in  1  GPU accepts the write this cycle
- vram_raddr_o  out  ADDR_W  read address
- vram_rdata_i  in  DATA_W  read pixel, synchronous 1-cycle latency
- intr_o  out  1  level interrupt

Behaviour:

Register map (offsets from BASE_ADDR):
- +0x00 ADDR
  - W: r_addr <= out[ADDR_W-1:0].
  - R: r_addr, zero-extended.
- +0x04 WRITE
  - W: push {out[DATA_W+15:16], out[ADDR_W-1:0]}.
  - R: 0.
- +0x08 RDATA
  - R: vram_rdata_i, zero-extended.
- +0x0C STATUS
  - R bits: [0] empty, [1] full, [2] ovf sticky, [3] fill_busy, [4] fill_done sticky, [5] ie, [15:8] count, others 0.
  - W: bit2 = 1 clears ovf; bit4 = 1 clears fill_done; bit5 is written directly into ie.
- +0x10 FILL
  - W: start a fill with colour out[DATA_W-1:0].
- +0x14 FILL_LEN
  - W/R: r_len[ADDR_W-1:0].

Decode and read path:
- iobus_in_o is combinational from the address.
- Writes take effect on the clk edge where iobus_wr_i = 1.
- Unmapped offsets inside the window: reads return 0, writes are ignored.

Read path:
- vram_raddr_o = r_addr.
- RDATA is valid from the second cycle after an ADDR write.

Write FIFO:
- Storage is circular, with count width clog2(FIFO_DEPTH)+1.
- Head drive: vram_we_o = !empty, and vram_waddr_o/vram_wdata_o show the head entry.
- Head stability: head, addr and data stay stable until the cycle vram_rdy_i = 1 with vram_we_o = 1, which pops the entry.
- No combinational path from vram_rdy_i to any output.
- Push and pop in the same cycle are allowed, including when full (pop frees the slot, count unchanged) and when empty (entry is not visible until the next cycle).
- CPU WRITE while full with no pop that cycle: entry dropped, ovf <= 1, FIFO unchanged.

Fill engine, states IDLE and FILL:
- IDLE -> FILL on a FILL write when r_len != 0.
  - Latch colour; f_addr <= r_addr; f_rem <= r_len; fill_done <= 0.
  - FILL write with r_len == 0: no-op, but fill_done <= 1.
- In FILL, each cycle the FIFO can accept an entry and no CPU WRITE pushes that cycle, push {colour, f_addr}.
  - f_addr increments modulo 2^ADDR_W (wraps to 0).
  - f_rem decrements.
- CPU WRITE has priority; the fill stalls that cycle.
- The fill never causes ovf.
- FILL -> IDLE on the push that makes f_rem = 0; fill_done <= 1 the same edge.
- FILL write while busy: ignored.
- ADDR/FILL_LEN writes while busy do not affect the running fill.
- fill_busy = (state == FILL); completion does not wait for the FIFO to drain.

Interrupt:
- intr_o = ie & fill_done, registered.
- Cleared only by a W1C to STATUS bit4 or by clearing ie.

Reset:
- All registers and the FIFO pointers/count go to 0, state = IDLE.
- Resulting outputs: vram_we_o = 0, intr_o = 0, vram_raddr_o = 0, STATUS reads 0x0001.
- Reset mid-fill or with the FIFO non-empty discards all pending entries immediately.

Test Plan:
1. Reset, then read STATUS -> 0x00000001; vram_we_o = 0; intr_o = 0.
2. WRITE 0x0ABC0123 with vram_rdy_i = 1 -> next cycle vram_we_o = 1, waddr = 0x0123, wdata = 0xABC for exactly one cycle; count returns to 0.
3. vram_rdy_i = 0, then 9 WRITEs (addr 0..8) -> STATUS full = 1, ovf = 1, count = 8. Raise vram_rdy_i -> addresses 0..7 drain in order. STATUS W1C 0x4 -> ovf = 0.
4. ADDR = 0xFFFE, FILL_LEN = 4, ie = 1, FILL 0x0F0, vram_rdy_i = 1 -> GPU sees addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 all with 0x0F0; fill_done = 1; intr_o = 1 until W1C 0x10.
5. During a fill with FILL_LEN = 6, issue a CPU WRITE to addr 0x0500 -> CPU entry inserted at that cycle; all 6 fill pixels are still written, contiguous addresses, no ovf.
6. Assert RST mid-fill with 3 FIFO entries pending -> vram_we_o = 0 immediately. After release, STATUS = 0x0001 and no further GPU writes occur.

Source files
------------

// File: rtl/iobus_vram_bridge.sv
// IOBUS register window that posts CPU pixel writes into a FIFO toward the GPU VRAM port,
// with a colour-fill engine, a VRAM readback path and a fill-complete interrupt.
module iobus_vram_bridge #(
  parameter logic [31:0] BASE_ADDR  = 32'h1100C00C,
  parameter int          ADDR_W     = 16,
  parameter int          DATA_W     = 12,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [31:0]       iobus_addr_i,
  input  logic              iobus_wr_i,
  input  logic [31:0]       iobus_out_i,
  output logic [31:0]       iobus_in_o,
  output logic              vram_we_o,
  output logic [ADDR_W-1:0] vram_waddr_o,
  output logic [DATA_W-1:0] vram_wdata_o,
  input  logic              vram_rdy_i,
  output logic [ADDR_W-1:0] vram_raddr_o,
  input  logic [DATA_W-1:0] vram_rdata_i,
  output logic              intr_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_W + ADDR_W;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  logic [31:0] offset;
  logic        in_win;
  logic [2:0]  reg_idx;
  logic        wr_addr, wr_write, wr_status, wr_fill, wr_len;

  state_t            state_q;
  logic [ADDR_W-1:0] r_addr_q, r_len_q, f_addr_q, f_rem_q;
  logic [DATA_W-1:0] colour_q;
  logic              ovf_q, done_q, ie_q, intr_q;
  logic              ovf_d, done_d, ie_d;

  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full, pop, can_push;
  logic             cpu_push, fill_push, push, fill_last, busy;
  logic [ENT_W-1:0] push_entry;
  logic             unused_ok;

  // Offsets are taken relative to BASE_ADDR so the window need not sit on a power-of-two boundary.
  assign offset  = iobus_addr_i - BASE_ADDR;
  assign in_win  = (offset < 32'h18) && (offset[1:0] == 2'b00);
  assign reg_idx = offset[4:2];

  assign wr_addr   = iobus_wr_i && in_win && (reg_idx == 3'd0);
  assign wr_write  = iobus_wr_i && in_win && (reg_idx == 3'd1);
  assign wr_status = iobus_wr_i && in_win && (reg_idx == 3'd3);
  assign wr_fill   = iobus_wr_i && in_win && (reg_idx == 3'd4);
  assign wr_len    = iobus_wr_i && in_win && (reg_idx == 3'd5);

  assign unused_ok = ^{iobus_out_i, offset};

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign busy      = (state_q == S_FILL);
  assign pop       = !empty && vram_rdy_i;
  assign can_push  = !full || pop;
  assign cpu_push  = wr_write && can_push;
  // A CPU write always owns the push slot, even when it is dropped for overflow.
  assign fill_push = busy && !wr_write && can_push;
  assign push      = cpu_push || fill_push;
  assign fill_last = fill_push && (f_rem_q == ADDR_W'(1));
  assign count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

  assign push_entry = wr_write ? {iobus_out_i[DATA_W+15:16], iobus_out_i[ADDR_W-1:0]}
                               : {colour_q, f_addr_q};

  assign vram_we_o    = !empty;
  assign vram_waddr_o = mem_q[rd_ptr_q][ADDR_W-1:0];
  assign vram_wdata_o = mem_q[rd_ptr_q][ENT_W-1:ADDR_W];
  assign vram_raddr_o = r_addr_q;
  assign intr_o       = intr_q;

  always_comb begin
    ovf_d  = ovf_q;
    done_d = done_q;
    ie_d   = ie_q;
    if (wr_status) begin
      if (iobus_out_i[2]) ovf_d = 1'b0;
      if (iobus_out_i[4]) done_d = 1'b0;
      ie_d = iobus_out_i[5];
    end
    if (wr_write && !can_push) ovf_d = 1'b1;
    if (wr_fill && !busy) done_d = (r_len_q == '0);
    // Completion wins over a same-cycle W1C so the event is never lost.
    if (fill_last) done_d = 1'b1;
  end

  always_comb begin
    iobus_in_o = 32'h0;
    if (in_win) begin
      case (reg_idx)
        3'd0: iobus_in_o = 32'(r_addr_q);
        3'd2: iobus_in_o = 32'(vram_rdata_i);
        3'd3: iobus_in_o = {16'h0, 8'(count_q), 2'b00, ie_q, done_q, busy, ovf_q, full, empty};
        3'd5: iobus_in_o = 32'(r_len_q);
        default: iobus_in_o = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      r_addr_q <= '0;
      r_len_q  <= '0;
      f_addr_q <= '0;
      f_rem_q  <= '0;
      colour_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      ie_q     <= 1'b0;
      intr_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (wr_addr) r_addr_q <= iobus_out_i[ADDR_W-1:0];
      if (wr_len)  r_len_q  <= iobus_out_i[ADDR_W-1:0];
      ovf_q  <= ovf_d;
      done_q <= done_d;
      ie_q   <= ie_d;
      intr_q <= ie_d && done_d;
      case (state_q)
        S_IDLE: begin
          if (wr_fill && (r_len_q != '0)) begin
            state_q  <= S_FILL;
            colour_q <= iobus_out_i[DATA_W-1:0];
            f_addr_q <= r_addr_q;
            f_rem_q  <= r_len_q;
          end
        end
        S_FILL: begin
          if (fill_push) begin
            f_addr_q <= f_addr_q + ADDR_W'(1);
            f_rem_q  <= f_rem_q - ADDR_W'(1);
            if (fill_last) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: tb/tb_iobus_vram_bridge.sv
// Directed plus randomized bench for iobus_vram_bridge: a queue-based scoreboard predicts
// every GPU write, and a small status model predicts every STATUS readback.
module tb_iobus_vram_bridge;

  localparam logic [31:0] BASE       = 32'h1100C00C;
  localparam int          DEPTH      = 8;
  localparam logic [31:0] OFF_ADDR   = 32'h00;
  localparam logic [31:0] OFF_WRITE  = 32'h04;
  localparam logic [31:0] OFF_RDATA  = 32'h08;
  localparam logic [31:0] OFF_STATUS = 32'h0C;
  localparam logic [31:0] OFF_FILL   = 32'h10;
  localparam logic [31:0] OFF_LEN    = 32'h14;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iobus_addr_i, iobus_out_i, iobus_in_o;
  logic        iobus_wr_i;
  logic        vram_we_o, vram_rdy_i, intr_o;
  logic [15:0] vram_waddr_o, vram_raddr_o;
  logic [11:0] vram_wdata_o, vram_rdata_i;

  iobus_vram_bridge #(
    .BASE_ADDR(BASE), .ADDR_W(16), .DATA_W(12), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .RST(rst),
    .iobus_addr_i(iobus_addr_i), .iobus_wr_i(iobus_wr_i), .iobus_out_i(iobus_out_i),
    .iobus_in_o(iobus_in_o),
    .vram_we_o(vram_we_o), .vram_waddr_o(vram_waddr_o), .vram_wdata_o(vram_wdata_o),
    .vram_rdy_i(vram_rdy_i), .vram_raddr_o(vram_raddr_o), .vram_rdata_i(vram_rdata_i),
    .intr_o(intr_o)
  );

  always #5 clk = ~clk;

  // GPU read port: synchronous, one cycle of latency, content is a fixed function of address.
  always @(posedge clk) vram_rdata_i <= vram_raddr_o[11:0] ^ 12'h5A5;

  int checks = 0;
  int passes = 0;
  int gpu_cnt = 0;
  int fill_seen = 0;
  int fill_seen_at_cpu = -1;
  bit m_ovf = 1'b0, m_done = 1'b0, m_ie = 1'b0;
  logic [27:0] cpu_q[$];
  logic [27:0] fill_q[$];
  logic [27:0] mon_obs, mon_exp;
  bit          mon_have, mon_cmp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_status(input int cnt, input bit busy);
    return (32'(cnt) << 8) | (32'(m_ie) << 5) | (32'(m_done) << 4) | (32'(busy) << 3) |
           (32'(m_ovf) << 2) | (32'(cnt == DEPTH) << 1) | 32'(cnt == 0);
  endfunction

  // Scoreboard: each accepted GPU write must be the next CPU entry or the next fill pixel.
  always @(negedge clk) begin
    if (vram_we_o === 1'b1 && vram_rdy_i === 1'b1) begin
      mon_obs = {vram_wdata_o, vram_waddr_o};
      gpu_cnt++;
      mon_have = 1'b1;
      mon_cmp  = 1'b1;
      if (cpu_q.size() > 0 && cpu_q[0] == mon_obs) begin
        mon_exp = cpu_q.pop_front();
        fill_seen_at_cpu = fill_seen;
        mon_cmp = 1'b0;
      end else if (fill_q.size() > 0) begin
        mon_exp = fill_q.pop_front();
        fill_seen++;
      end else if (cpu_q.size() > 0) begin
        mon_exp = cpu_q.pop_front();
      end else begin
        mon_have = 1'b0;
      end
      $display("gpu write addr=0x%04h data=0x%03h", vram_waddr_o, vram_wdata_o);
      check("gpu_expected", 32'(mon_have), 32'd1);
      if (mon_have && mon_cmp) check("gpu_write", 32'(mon_obs), 32'(mon_exp));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] off, input logic [31:0] data);
    if (off == OFF_WRITE) begin
      if (cpu_q.size() == DEPTH && !vram_rdy_i) m_ovf = 1'b1;
      else cpu_q.push_back({data[27:16], data[15:0]});
    end
    if (off == OFF_STATUS) begin
      if (data[2]) m_ovf = 1'b0;
      if (data[4]) m_done = 1'b0;
      m_ie = data[5];
    end
    iobus_addr_i = BASE + off;
    iobus_out_i  = data;
    iobus_wr_i   = 1'b1;
    tick();
    iobus_wr_i   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] d);
    iobus_addr_i = addr;
    iobus_wr_i   = 1'b0;
    #1;
    d = iobus_in_o;
  endtask

  task automatic check_status(input string tag, input int cnt, input bit busy);
    logic [31:0] d;
    bus_read(BASE + OFF_STATUS, d);
    check(tag, d, exp_status(cnt, busy));
    check({tag, "_intr"}, 32'(intr_o), 32'(m_ie && m_done));
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (cpu_q.size() == 0 && fill_q.size() == 0 && vram_we_o == 1'b0) break;
      tick();
    end
    check(tag, 32'(cpu_q.size() + fill_q.size()), 32'd0);
    check({tag, "_we"}, 32'(vram_we_o), 32'd0);
  endtask

  initial begin
    #100us;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int snap;
    rst = 1'b1;
    iobus_addr_i = '0; iobus_out_i = '0; iobus_wr_i = 1'b0; vram_rdy_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check_status("t1_status", 0, 1'b0);
    check("t1_we", 32'(vram_we_o), 32'd0);
    check("t1_raddr", 32'(vram_raddr_o), 32'd0);

    // Register readback, RDATA latency and unmapped reads
    bus_write(OFF_ADDR, 32'h0001_1234);
    check("rd_raddr", 32'(vram_raddr_o), 32'h1234);
    tick();
    bus_read(BASE + OFF_RDATA, d);
    check("rd_rdata", d, 32'h234 ^ 32'h5A5);
    bus_read(BASE + OFF_ADDR, d);
    check("rd_addr", d, 32'h1234);
    bus_write(OFF_LEN, 32'h0001_2345);
    bus_read(BASE + OFF_LEN, d);
    check("rd_len", d, 32'h2345);
    bus_read(BASE + OFF_WRITE, d);
    check("rd_write_zero", d, 32'h0);
    bus_read(BASE + 32'h18, d);
    check("rd_past_window", d, 32'h0);
    bus_read(BASE - 32'h4, d);
    check("rd_below_window", d, 32'h0);
    bus_write(OFF_LEN, 32'h0);

    // Single posted write
    vram_rdy_i = 1'b1;
    bus_write(OFF_WRITE, 32'h0ABC_0123);
    check("t2_we", 32'(vram_we_o), 32'd1);
    check("t2_waddr", 32'(vram_waddr_o), 32'h0123);
    check("t2_wdata", 32'(vram_wdata_o), 32'hABC);
    tick();
    check("t2_we_off", 32'(vram_we_o), 32'd0);
    check_status("t2_status", cpu_q.size(), 1'b0);

    // Fill the FIFO, overflow, drain in order, clear ovf
    vram_rdy_i = 1'b0;
    for (int i = 0; i < 9; i++) bus_write(OFF_WRITE, {4'h0, 12'(32'h100 + i), 16'(i)});
    check_status("t3_full", cpu_q.size(), 1'b0);
    vram_rdy_i = 1'b1;
    wait_drain("t3_drain");
    check_status("t3_drained", 0, 1'b0);
    bus_write(OFF_STATUS, 32'h4);
    check_status("t3_ovf_clear", 0, 1'b0);

    // Zero-length fill only sets fill_done
    bus_write(OFF_FILL, 32'h123);
    m_done = 1'b1;
    check_status("t_zero_fill", 0, 1'b0);
    bus_write(OFF_STATUS, 32'h10);

    // Random CPU writes against random GPU back-pressure
    for (int i = 0; i < 120; i++) begin
      vram_rdy_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) bus_write(OFF_WRITE, {4'h0, 12'($urandom), 16'($urandom)});
      else tick();
      if (i % 15 == 14) check_status($sformatf("rnd_%0d", i), cpu_q.size(), 1'b0);
    end
    vram_rdy_i = 1'b1;
    wait_drain("rnd_drain");
    check_status("rnd_final", 0, 1'b0);
    bus_write(OFF_STATUS, 32'h4);

    // Fill wrapping past the top of VRAM, with interrupt
    bus_write(OFF_ADDR, 32'hFFFE);
    bus_write(OFF_LEN, 32'h4);
    bus_write(OFF_STATUS, 32'h20);
    for (int k = 0; k < 4; k++) fill_q.push_back({12'h0F0, 16'(32'hFFFE + k)});
    bus_write(OFF_FILL, 32'h0F0);
    wait_drain("t4_drain");
    m_done = 1'b1;
    check_status("t4_done", 0, 1'b0);
    check("t4_intr", 32'(intr_o), 32'd1);
    bus_write(OFF_STATUS, 32'h30);
    check_status("t4_cleared", 0, 1'b0);
    bus_write(OFF_STATUS, 32'h0);

    // CPU write interleaved into a running fill; busy-time FILL_LEN/FILL writes are inert
    bus_write(OFF_ADDR, 32'h0200);
    bus_write(OFF_LEN, 32'h6);
    for (int k = 0; k < 6; k++) fill_q.push_back({12'h5A5, 16'(32'h0200 + k)});
    fill_seen = 0;
    fill_seen_at_cpu = -1;
    bus_write(OFF_FILL, 32'h5A5);
    tick();
    bus_write(OFF_WRITE, 32'h0777_0500);
    bus_write(OFF_LEN, 32'h2);
    bus_write(OFF_FILL, 32'h111);
    wait_drain("t5_drain");
    m_done = 1'b1;
    check("t5_cpu_slot", 32'(fill_seen_at_cpu), 32'd1);
    check_status("t5_status", 0, 1'b0);
    bus_write(OFF_STATUS, 32'h10);

    // Reset in the middle of a fill with entries pending
    bus_write(OFF_ADDR, 32'h0300);
    bus_write(OFF_LEN, 32'hA);
    vram_rdy_i = 1'b0;
    bus_write(OFF_FILL, 32'h0AA);
    tick(); tick(); tick();
    check_status("t6_pending", 3, 1'b1);
    rst = 1'b1;
    #1;
    check("t6_we_reset", 32'(vram_we_o), 32'd0);
    check("t6_intr_reset", 32'(intr_o), 32'd0);
    cpu_q.delete();
    fill_q.delete();
    m_ovf = 1'b0; m_done = 1'b0; m_ie = 1'b0;
    tick(); tick();
    rst = 1'b0;
    snap = gpu_cnt;
    vram_rdy_i = 1'b1;
    repeat (20) tick();
    check("t6_no_writes", 32'(gpu_cnt), 32'(snap));
    check_status("t6_status", 0, 1'b0);
    check("t6_raddr", 32'(vram_raddr_o), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
